child_response_collector: RTL and testbench
===========================================

Name: child_response_collector

Overview:
- Fan-in counterpart to the root-level fan-out. The root broadcasts to NUM_CHILDREN child instances; this block gathers their responses back toward the parent.
- Each child has a valid/ready channel. The collector arbitrates among them round-robin and forwards one beat at a time through a registered upstream valid/ready port.
- Each forwarded beat is tagged with the index of the child that produced it, and the block counts completed beats.

Parameters:
- NUM_CHILDREN, 15, number of child channels; legal range 2..16.
- DATA_W, 32, payload width per beat.
- SRC_W, 4, width of the source tag; must be >= clog2(NUM_CHILDREN).
- CNT_W, 16, width of the saturating beat counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- child_valid  in  NUM_CHILDREN  per-child beat valid.
- child_data  in  NUM_CHILDREN*DATA_W  flattened payloads; child i occupies bits [i*DATA_W +: DATA_W].
- child_ready  out  NUM_CHILDREN  per-child accept; one-hot or all zero.
- up_valid  out  1  registered upstream beat valid.
- up_data  out  DATA_W  registered upstream payload.
- up_src  out  SRC_W  registered index of the child that sent the beat.
- up_ready  in  1  upstream accept.
- beat_count  out  CNT_W  number of upstream transfers completed, saturating.
- idle  out  1  high when no child_valid is asserted and up_valid is 0.

Behaviour:
- Reset values:
  - up_valid=0, up_data=0, up_src=0, beat_count=0.
  - Internal round-robin pointer ptr=0.
  - child_ready=0 for every cycle in which rst is high.
- Load enable: load_en = !up_valid || up_ready. The output register is free or is being drained this cycle.
- Grant selection (combinational):
  - g = the first index i with child_valid[i]=1, searching ptr, ptr+1, ..., NUM_CHILDREN-1, 0, ..., ptr-1.
  - If no child is valid, there is no grant.
- Ready: child_ready[g] = load_en && grant exists; all other bits are 0.
  - Combinational paths child_valid->child_ready and up_ready->child_ready are permitted and required.
- Child transfer: child_valid[g] && child_ready[g] in a cycle. On the next edge:
  - up_valid <= 1.
  - up_data <= payload of child g.
  - up_src <= g, zero-extended to SRC_W.
  - ptr <= g+1, wrapping from NUM_CHILDREN-1 to 0.
- Drain: if up_valid && up_ready and there is no child transfer in the same cycle, up_valid <= 0. up_data and up_src hold their last values.
- Simultaneous drain and load: the new beat replaces the old one in the same edge. There is no bubble, so throughput is 1 beat/cycle under continuous up_ready.
- Latency: one cycle from the child handshake to up_valid.
- Backpressure:
  - up_valid=1 && up_ready=0 means load_en=0, all child_ready=0, and up_valid/up_data/up_src/ptr all hold.
  - The output must stay stable until accepted.
- Fairness: ptr advances only on a child transfer. Under continuous requests from all children, each child gets exactly one grant per NUM_CHILDREN transfers.
- Beat counter: increments on each edge where up_valid && up_ready. It saturates at 2^CNT_W-1 and does not wrap.
- Child obligation: a child holds valid and data stable until it is accepted. The collector does not check this.
- Reset mid-operation:
  - Any beat held in the output register is discarded.
  - Pending child beats are not accepted during reset and are arbitrated from ptr=0 afterwards.
  - beat_count clears.
- Out-of-range indices: child indices >= NUM_CHILDREN do not exist; up_src never exceeds NUM_CHILDREN-1.

Test Plan:
- Single child: after reset, child 7 presents 0xDEADBEEF with up_ready=1.
  - child_ready[7]=1 in that cycle.
  - Next cycle: up_valid=1, up_data=0xDEADBEEF, up_src=7.
  - beat_count=1 after the drain.
- Full contention: all 15 children valid continuously, up_ready=1, starting from ptr=0.
  - up_src sequence is 0,1,...,14,0,1 with no gaps.
  - beat_count=17 after 17 transfers.
- Backpressure: children 2 and 5 valid, up_ready=0 for 4 cycles after the first beat loads.
  - up_src=2 holds for 4 cycles and child_ready stays 0.
  - When up_ready returns to 1, child 5 loads the same cycle; next cycle up_src=5.
- Wrap/skip: ptr=14 (last grant was child 13), only children 1 and 14 valid.
  - Grants are 14 then 1; ptr ends at 2.
- Reset mid-op: rst asserted for one cycle while up_valid=1 with beat_count=9.
  - Next cycle: up_valid=0, beat_count=0, and child_ready=0 during the reset cycle.
  - The first grant after reset goes to the lowest valid index.
- Saturation: CNT_W=4 with 20 continuous transfers.
  - beat_count reaches 15 and stays there.
  - idle=1 once all children deassert valid and up_valid=0.

Source files
------------

// File: rtl/child_response_collector.sv
`default_nettype none
// ============================================================================
//  Module      : child_response_collector
//  Description : Fan-in collector. Arbitrates round-robin among NUM_CHILDREN
//                valid/ready child channels and forwards one beat per cycle
//                through a registered upstream valid/ready port. Each beat is
//                tagged with the index of its child, and completed upstream
//                transfers are counted in a saturating counter.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                child_valid/data  - per-child beat in (flattened payloads)
//                child_ready       - per-child accept, one-hot or zero
//                up_valid/data/src - registered upstream beat and source tag
//                up_ready          - upstream accept
//                beat_count        - saturating count of upstream transfers
//                idle              - no child requesting and output empty
//  Revision    : 1.0 - initial release
// ============================================================================
module child_response_collector #(
    parameter int NUM_CHILDREN = 15,
    parameter int DATA_W       = 32,
    parameter int SRC_W        = 4,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    output logic                           up_valid,
    output logic [DATA_W-1:0]              up_data,
    output logic [SRC_W-1:0]               up_src,
    input  logic                           up_ready,
    output logic [CNT_W-1:0]               beat_count,
    output logic                           idle
);

    localparam int IDX_W = $clog2(NUM_CHILDREN);

    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_grant;
    logic              w_found;
    logic [IDX_W:0]    w_sum;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_grant_data;
    logic [IDX_W-1:0]  w_ptr_next;
    logic              w_load_en;
    logic              w_xfer;

    // Output register is empty or being drained this cycle.
    assign w_load_en = !up_valid || up_ready;

    // Round-robin search: the first valid child at or after r_ptr, wrapping.
    // The sum is one bit wider than an index so ptr+k never overflows before
    // the modulo correction.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_CHILDREN)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_CHILDREN);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && child_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Payload mux for the granted child.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_grant_data = child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_grant == IDX_W'(NUM_CHILDREN - 1)) ? '0 : w_grant + 1'b1;

    // Reset gates the handshake so no child beat is consumed and then lost.
    assign w_xfer = w_load_en && w_found && !rst;

    assign child_ready = w_xfer
                       ? ({{(NUM_CHILDREN-1){1'b0}}, 1'b1} << w_grant)
                       : '0;

    assign idle = !(|child_valid) && !up_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_valid   <= 1'b0;
            up_data    <= '0;
            up_src     <= '0;
            beat_count <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_xfer) begin
                // A new beat replaces a draining one in the same edge.
                up_valid <= 1'b1;
                up_data  <= w_grant_data;
                up_src   <= SRC_W'(w_grant);
                r_ptr    <= w_ptr_next;
            end else if (up_ready) begin
                up_valid <= 1'b0;
            end
            if (up_valid && up_ready && (beat_count != {CNT_W{1'b1}})) begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_child_response_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_child_response_collector
//  Description : Self-checking bench. A second instance with a 4-bit counter
//                shares all stimulus to observe counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_child_response_collector;

    localparam int N  = 15;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    child_valid;
    logic [N*DW-1:0] child_data;
    logic [N-1:0]    child_ready;
    logic            up_valid;
    logic [DW-1:0]   up_data;
    logic [SW-1:0]   up_src;
    logic            up_ready;
    logic [15:0]     beat_count;
    logic            idle;

    logic [N-1:0]    s_child_ready;
    logic            s_up_valid;
    logic [DW-1:0]   s_up_data;
    logic [SW-1:0]   s_up_src;
    logic [3:0]      s_beat_count;
    logic            s_idle;

    child_response_collector #(.NUM_CHILDREN(N), .DATA_W(DW), .SRC_W(SW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
        .child_ready(child_ready), .up_valid(up_valid), .up_data(up_data),
        .up_src(up_src), .up_ready(up_ready), .beat_count(beat_count), .idle(idle)
    );

    child_response_collector #(.NUM_CHILDREN(N), .DATA_W(DW), .SRC_W(SW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .child_valid(child_valid), .child_data(child_data),
        .child_ready(s_child_ready), .up_valid(s_up_valid), .up_data(s_up_data),
        .up_src(s_up_src), .up_ready(up_ready), .beat_count(s_beat_count), .idle(s_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Child-side sources: a pending beat is held until it is accepted.
    bit          pend  [N];
    logic [31:0] pdata [N];

    // Reference model of the collector.
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_cnt;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] r;
        g = model_grant();
        r = '0;
        if (!rst && g >= 0 && (!m_valid || up_ready)) r[g] = 1'b1;
        return r;
    endfunction

    function automatic bit exp_idle();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b0;
        return !m_valid;
    endfunction

    function automatic int sat_cnt();
        return (m_cnt > 15) ? 15 : m_cnt;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            child_valid[i]          = pend[i];
            child_data[i*DW +: DW]  = pdata[i];
        end
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick(output int g);
        int  gg;
        bit  ld;
        gg = model_grant();
        g  = -1;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            ld = (!m_valid || up_ready) && gg >= 0;
            if (m_valid && up_ready) m_cnt++;
            if (ld) begin
                m_valid = 1; m_data = pdata[gg]; m_src = gg;
                m_ptr = (gg + 1) % N; pend[gg] = 1'b0; g = gg;
            end else if (m_valid && up_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        int g;
        rst = 1'b1;
        drive();
        #1;
        tick(g);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int g;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pdata[i] = $urandom(); end
        up_ready = 1'b1;
        rst = 1'b1;
        drive(); #1;
        checks++;
        if (child_ready !== '0) begin errors++; $display("FAIL reset_ready: got %h expected 0", child_ready); end
        tick(g);
        checks++;
        if (up_valid !== 1'b0 || up_data !== '0 || up_src !== '0 || beat_count !== '0 || s_beat_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d c=%0d sc=%0d expected all zero",
                     up_valid, up_data, up_src, beat_count, s_beat_count);
        end
        rst = 1'b0;
        clear_pend(); drive();
    endtask

    task automatic test_single_child();
        int g;
        do_reset();
        clear_pend();
        pend[7] = 1'b1; pdata[7] = 32'hDEADBEEF;
        up_ready = 1'b1;
        drive(); #1;
        checks++;
        if (child_ready !== 15'h0080) begin errors++; $display("FAIL single_ready: got %h expected 0080", child_ready); end
        tick(g);
        drive(); #1;
        checks++;
        if (up_valid !== 1'b1 || up_data !== 32'hDEADBEEF || up_src !== 4'd7) begin
            errors++;
            $display("FAIL single_beat: got v=%b d=%h s=%0d expected v=1 d=deadbeef s=7", up_valid, up_data, up_src);
        end
        tick(g);
        checks++;
        if (beat_count !== 16'd1 || up_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_drain: got c=%0d v=%b idle=%b expected c=1 v=0 idle=1", beat_count, up_valid, idle);
        end
    endtask

    // All children valid continuously; also covers 4-bit counter saturation.
    task automatic test_full_contention();
        int g;
        do_reset();
        up_ready = 1'b1;
        for (int t = 0; t < 21; t++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) begin pend[i] = 1'b1; pdata[i] = $urandom(); end
            drive(); #1;
            checks++;
            if (child_ready !== exp_ready()) begin
                errors++; $display("FAIL contention_ready t=%0d: got %h expected %h", t, child_ready, exp_ready());
            end
            tick(g);
            checks++;
            if (up_valid !== 1'b1 || up_src !== SW'(t % N) || up_data !== m_data) begin
                errors++;
                $display("FAIL contention_src t=%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         t, up_valid, up_src, up_data, t % N, m_data);
            end
            checks++;
            if (s_beat_count !== 4'(sat_cnt())) begin
                errors++; $display("FAIL sat_count t=%0d: got %0d expected %0d", t, s_beat_count, sat_cnt());
            end
            if (t == 16) begin
                checks++;
                if (beat_count !== 16'd16) begin errors++; $display("FAIL contention_count16: got %0d expected 16", beat_count); end
            end
        end
        clear_pend(); drive();
        tick(g);
        tick(g);
        checks++;
        if (beat_count !== 16'd21 || s_beat_count !== 4'd15 || idle !== 1'b1 || s_idle !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: got c=%0d sc=%0d idle=%b expected c=21 sc=15 idle=1", beat_count, s_beat_count, idle);
        end
    endtask

    task automatic test_backpressure();
        int g;
        do_reset();
        clear_pend();
        pend[2] = 1'b1; pdata[2] = 32'h2222_0002;
        pend[5] = 1'b1; pdata[5] = 32'h5555_0005;
        up_ready = 1'b1;
        drive(); #1;
        tick(g);
        up_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(); #1;
            checks++;
            if (child_ready !== '0) begin errors++; $display("FAIL bp_ready t=%0d: got %h expected 0", t, child_ready); end
            tick(g);
            checks++;
            if (up_valid !== 1'b1 || up_src !== 4'd2 || up_data !== 32'h2222_0002) begin
                errors++; $display("FAIL bp_hold t=%0d: got v=%b s=%0d d=%h expected v=1 s=2 d=22220002", t, up_valid, up_src, up_data);
            end
        end
        up_ready = 1'b1;
        drive(); #1;
        checks++;
        if (child_ready !== 15'h0020) begin errors++; $display("FAIL bp_release_ready: got %h expected 0020", child_ready); end
        tick(g);
        checks++;
        if (up_valid !== 1'b1 || up_src !== 4'd5 || up_data !== 32'h5555_0005) begin
            errors++; $display("FAIL bp_release: got v=%b s=%0d d=%h expected v=1 s=5 d=55550005", up_valid, up_src, up_data);
        end
        drive(); tick(g);
    endtask

    task automatic test_wrap_skip();
        int g;
        do_reset();
        clear_pend();
        up_ready = 1'b1;
        pend[13] = 1'b1; pdata[13] = 32'h13;
        drive(); #1; tick(g);
        pend[1] = 1'b1; pdata[1] = 32'h01;
        pend[14] = 1'b1; pdata[14] = 32'h14;
        drive(); #1; tick(g);
        checks++;
        if (up_src !== 4'd14) begin errors++; $display("FAIL wrap_first: got %0d expected 14", up_src); end
        drive(); #1; tick(g);
        checks++;
        if (up_src !== 4'd1) begin errors++; $display("FAIL wrap_second: got %0d expected 1", up_src); end
        // Pointer should now be 2: child 2 wins over child 0.
        pend[0] = 1'b1; pdata[0] = 32'h00;
        pend[2] = 1'b1; pdata[2] = 32'h02;
        drive(); #1;
        checks++;
        if (child_ready !== 15'h0004) begin errors++; $display("FAIL wrap_ptr: got %h expected 0004", child_ready); end
        tick(g);
        clear_pend(); drive(); tick(g);
    endtask

    task automatic test_reset_midop();
        int g;
        do_reset();
        clear_pend();
        up_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            pend[3] = 1'b1; pdata[3] = $urandom();
            drive(); #1; tick(g);
        end
        checks++;
        if (beat_count !== 16'd9 || up_valid !== 1'b1) begin
            errors++; $display("FAIL midop_setup: got c=%0d v=%b expected c=9 v=1", beat_count, up_valid);
        end
        pend[3] = 1'b1; pend[9] = 1'b1; pend[11] = 1'b1;
        rst = 1'b1;
        drive(); #1;
        checks++;
        if (child_ready !== '0) begin errors++; $display("FAIL midop_rst_ready: got %h expected 0", child_ready); end
        tick(g);
        rst = 1'b0;
        checks++;
        if (up_valid !== 1'b0 || beat_count !== 16'd0) begin
            errors++; $display("FAIL midop_after: got v=%b c=%0d expected v=0 c=0", up_valid, beat_count);
        end
        drive(); #1;
        checks++;
        if (child_ready !== 15'h0008) begin errors++; $display("FAIL midop_first_grant: got %h expected 0008", child_ready); end
        tick(g);
        clear_pend(); drive(); tick(g); tick(g);
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            rst      = ($urandom_range(0, 60) == 0);
            up_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin pend[i] = 1'b1; pdata[i] = $urandom(); end
            end
            drive(); #1;
            checks++;
            if (child_ready !== exp_ready() || idle !== exp_idle()) begin
                errors++;
                $display("FAIL rand_comb t=%0d: got rdy=%h idle=%b expected rdy=%h idle=%b",
                         t, child_ready, idle, exp_ready(), exp_idle());
            end
            tick(g);
            checks++;
            if (up_valid !== m_valid || up_data !== m_data || up_src !== SW'(m_src)
                || beat_count !== 16'(m_cnt) || s_beat_count !== 4'(sat_cnt())) begin
                errors++;
                $display("FAIL rand_regs t=%0d: got v=%b d=%h s=%0d c=%0d sc=%0d expected v=%b d=%h s=%0d c=%0d sc=%0d",
                         t, up_valid, up_data, up_src, beat_count, s_beat_count,
                         m_valid, m_data, m_src, m_cnt, sat_cnt());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; up_ready = 1'b0; child_valid = '0; child_data = '0;
        m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_cnt = 0;
        clear_pend();
        for (int i = 0; i < N; i++) pdata[i] = '0;
        @(negedge clk);
        test_reset();
        test_single_child();
        test_full_contention();
        test_backpressure();
        test_wrap_skip();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
